vblake_round_ctrl: RTL and testbench

//  Iterative vBlake compression-round sequencer sitting around one external mix_vg G-function pipeline.

---
 rtl/vblake_round_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_vblake_round_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vblake_round_ctrl.sv
// vBlake compression-round sequencer around an external mix_vg G pipeline.
// Holds v[0..15], issues column/diagonal G ops and writes results back.
module vblake_round_ctrl #(
  parameter int ROUNDS = 16,
  parameter int G_LAT  = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1023:0] v_in,
  input  logic [1023:0] m_in,
  input  logic [1023:0] c_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [1023:0] v_out,
  output logic [63:0]   g_a,
  output logic [63:0]   g_b,
  output logic [63:0]   g_c,
  output logic [63:0]   g_d,
  output logic [63:0]   g_m0,
  output logic [63:0]   g_m1,
  input  logic [63:0]   g_a_r,
  input  logic [63:0]   g_b_r,
  input  logic [63:0]   g_c_r,
  input  logic [63:0]   g_d_r
);

  localparam logic [7:0] LAST = 8'(ROUNDS - 1);

  typedef enum logic [1:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [63:0]   v_q [16];
  logic [1023:0] m_q;
  logic [1023:0] c_q;
  logic [7:0]    round_q;
  logic [3:0]    srow_q;
  logic          step_q;
  logic [1:0]    gi_q;

  logic [G_LAT-1:0] tag_v;
  logic [1:0]       tag_i [G_LAT];

  logic        accept;
  logic        issue;
  logic        wb;
  logic        last_wb;
  logic [63:0] sig_row;
  logic [2:0]  j;
  logic [3:0]  s0;
  logic [3:0]  s1;
  logic [15:0] is_slot;
  logic [15:0] wb_slot;

  // Packed {a,b,c,d} slot indices; 2-bit adds give the %4 wrap.
  function automatic logic [15:0] slots(
    input logic [1:0] g,
    input logic       diag
  );
    logic [1:0] o1, o2, o3;
    o1 = g + {1'b0, diag};
    o2 = g + {diag, 1'b0};
    o3 = g + {diag, diag};
    return {2'b00, g, 2'b01, o1, 2'b10, o2, 2'b11, o3};
  endfunction

  // BLAKE2 sigma rows, nibble k = sigma[row][k].
  function automatic logic [63:0] sigma(input logic [3:0] r);
    logic [63:0] s;
    unique case (r)
      4'd0:    s = 64'hFEDCBA9876543210;
      4'd1:    s = 64'h357B20C16DF984AE;
      4'd2:    s = 64'h491763EADF250C8B;
      4'd3:    s = 64'h8F04A562EBCD1397;
      4'd4:    s = 64'hD386CB1EFA427509;
      4'd5:    s = 64'h91EF57D438B0A6C2;
      4'd6:    s = 64'hB8293670A4DEF15C;
      4'd7:    s = 64'hA2684F05931CE7BD;
      4'd8:    s = 64'h5A417D2C803B9EF6;
      4'd9:    s = 64'h0DC3E9BF5167482A;
      default: s = 64'hFEDCBA9876543210;
    endcase
    return s;
  endfunction

  assign wb      = tag_v[G_LAT-1];
  assign last_wb = wb && (tag_i[G_LAT-1] == 2'd3);
  assign sig_row = sigma(srow_q);
  assign j       = {step_q, gi_q};
  assign s0      = sig_row[{j, 3'b000} +: 4];
  assign s1      = sig_row[{j, 3'b100} +: 4];
  assign is_slot = slots(gi_q, step_q);
  assign wb_slot = slots(tag_i[G_LAT-1], step_q);

  for (genvar k = 0; k < 16; k++) begin : g_vout
    assign v_out[64*k +: 64] = v_q[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    issue     = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        issue = 1'b1;
        if (gi_q == 2'd3) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (last_wb) begin
          if (step_q && round_q == LAST)
            state_nxt = S_DONE;
          else
            state_nxt = S_ISSUE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 16; k++) v_q[k] <= '0;
      m_q     <= '0;
      c_q     <= '0;
      round_q <= '0;
      srow_q  <= '0;
      step_q  <= 1'b0;
      gi_q    <= '0;
      tag_v   <= '0;
      for (int i = 0; i < G_LAT; i++) tag_i[i] <= '0;
      g_a  <= '0;
      g_b  <= '0;
      g_c  <= '0;
      g_d  <= '0;
      g_m0 <= '0;
      g_m1 <= '0;
    end else begin
      tag_v[0] <= issue;
      tag_i[0] <= gi_q;
      for (int i = 1; i < G_LAT; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_i[i] <= tag_i[i-1];
      end
      if (accept) begin
        for (int k = 0; k < 16; k++)
          v_q[k] <= v_in[64*k +: 64];
        m_q     <= m_in;
        c_q     <= c_in;
        round_q <= '0;
        srow_q  <= '0;
        step_q  <= 1'b0;
        gi_q    <= '0;
      end
      if (issue) begin
        g_a  <= v_q[is_slot[15:12]];
        g_b  <= v_q[is_slot[11:8]];
        g_c  <= v_q[is_slot[7:4]];
        g_d  <= v_q[is_slot[3:0]];
        g_m0 <= m_q[{s0, 6'd0} +: 64] ^ c_q[{s1, 6'd0} +: 64];
        g_m1 <= m_q[{s1, 6'd0} +: 64] ^ c_q[{s0, 6'd0} +: 64];
        gi_q <= gi_q + 2'd1;
      end
      if (wb) begin
        v_q[wb_slot[15:12]] <= g_a_r;
        v_q[wb_slot[11:8]]  <= g_b_r;
        v_q[wb_slot[7:4]]   <= g_c_r;
        v_q[wb_slot[3:0]]   <= g_d_r;
      end
      // Step flips on the final writeback so the next issue sees new v.
      if (state == S_WAIT && last_wb) begin
        step_q <= ~step_q;
        if (step_q) begin
          round_q <= round_q + 8'd1;
          srow_q  <= (srow_q == 4'd9) ? 4'd0 : srow_q + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vblake_round_ctrl.sv
// Directed bench for vblake_round_ctrl with a behavioural mix_vg stub
// and an independent software model of the full compression.
module tb_vblake_round_ctrl;

  localparam int G_LAT = 5;
  localparam int NST   = G_LAT - 1;

  localparam int SIG [10][16] = '{
    '{ 0, 1, 2, 3, 4, 5, 6, 7, 8, 9,10,11,12,13,14,15},
    '{14,10, 4, 8, 9,15,13, 6, 1,12, 0, 2,11, 7, 5, 3},
    '{11, 8,12, 0, 5, 2,15,13,10,14, 3, 6, 7, 1, 9, 4},
    '{ 7, 9, 3, 1,13,12,11,14, 2, 6, 5,10, 4, 0,15, 8},
    '{ 9, 0, 5, 7, 2, 4,10,15,14, 1,11,12, 6, 8, 3,13},
    '{ 2,12, 6,10, 0,11, 8, 3, 4,13, 7, 5,15,14, 1, 9},
    '{12, 5, 1,15,14,13, 4,10, 0, 7, 6, 3, 9, 2, 8,11},
    '{13,11, 7,14,12, 1, 3, 9, 5, 0,15, 4, 8, 6, 2,10},
    '{ 6,15,14, 9,11, 3, 0, 8,12, 2,13, 7, 1, 4,10, 5},
    '{10, 2, 8, 4, 7, 6, 1, 5,15,11, 9,14, 3,12,13, 0}
  };

  logic          clk = 0;
  logic          rst_n = 0;
  logic          in_valid = 0;
  logic          in_ready;
  logic [1023:0] v_in = '0;
  logic [1023:0] m_in = '0;
  logic [1023:0] c_in = '0;
  logic          out_valid;
  logic          out_ready = 0;
  logic [1023:0] v_out;
  logic [63:0]   g_a, g_b, g_c, g_d, g_m0, g_m1;
  logic [63:0]   g_a_r, g_b_r, g_c_r, g_d_r;

  int n_chk = 0;
  int n_fail = 0;

  vblake_round_ctrl #(.ROUNDS(16), .G_LAT(G_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .v_in(v_in), .m_in(m_in), .c_in(c_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .v_out(v_out),
    .g_a(g_a), .g_b(g_b), .g_c(g_c), .g_d(g_d),
    .g_m0(g_m0), .g_m1(g_m1),
    .g_a_r(g_a_r), .g_b_r(g_b_r),
    .g_c_r(g_c_r), .g_d_r(g_d_r)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [255:0] gfun(input logic [383:0] x);
    logic [63:0] a, b, c, d, m0, m1;
    {a, b, c, d, m0, m1} = x;
    a = a + b + m0; d = rotr(d ^ a, 32);
    c = c + d;      b = rotr(b ^ c, 24);
    a = a + b + m1; d = rotr(d ^ a, 16);
    c = c + d;      b = rotr(b ^ c, 63);
    return {a, b, c, d};
  endfunction

  // mix_vg stand-in: results appear G_LAT edges after the operand edge.
  logic [383:0] gp [NST];
  always @(posedge clk) begin
    gp[0] <= {g_a, g_b, g_c, g_d, g_m0, g_m1};
    for (int i = 1; i < NST; i++) gp[i] <= gp[i-1];
  end
  assign {g_a_r, g_b_r, g_c_r, g_d_r} = gfun(gp[NST-1]);

  function automatic logic [1023:0] ref_model(
    input logic [1023:0] vi, input logic [1023:0] mi,
    input logic [1023:0] ci
  );
    logic [63:0] v [16];
    logic [63:0] m [16];
    logic [63:0] c [16];
    logic [1023:0] r;
    int ia, ib, ic, id, jj, s0, s1, row;
    for (int k = 0; k < 16; k++) begin
      v[k] = vi[64*k +: 64];
      m[k] = mi[64*k +: 64];
      c[k] = ci[64*k +: 64];
    end
    for (int rd = 0; rd < 16; rd++) begin
      row = rd % 10;
      for (int st = 0; st < 2; st++) begin
        for (int gi = 0; gi < 4; gi++) begin
          ia = gi;
          ib = 4 + ((st == 1) ? (gi + 1) % 4 : gi);
          ic = 8 + ((st == 1) ? (gi + 2) % 4 : gi);
          id = 12 + ((st == 1) ? (gi + 3) % 4 : gi);
          jj = 4 * st + gi;
          s0 = SIG[row][2*jj];
          s1 = SIG[row][2*jj+1];
          {v[ia], v[ib], v[ic], v[id]} = gfun({v[ia], v[ib], v[ic],
            v[id], m[s0] ^ c[s1], m[s1] ^ c[s0]});
        end
      end
    end
    for (int k = 0; k < 16; k++) r[64*k +: 64] = v[k];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_v(input string tag, input logic [1023:0] obs,
                       input logic [1023:0] exp);
    for (int k = 0; k < 16; k++)
      chk($sformatf("%s[%0d]", tag, k), obs[64*k +: 64], exp[64*k +: 64]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [1023:0] v, input logic [1023:0] m,
                           input logic [1023:0] c);
    v_in = v; m_in = m; c_in = c;
    in_valid = 1;
    tick();
    in_valid = 0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 400 && !out_valid; i++) tick();
    chk({tag, "_done"}, 64'(out_valid), 64'd1);
  endtask

  function automatic logic [1023:0] rnd1024();
    logic [1023:0] r;
    for (int k = 0; k < 32; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction

  logic [1023:0] va, ma, ca, ea, vb, mb, cb, eb, vx;
  logic [63:0]   w1;

  initial begin
    // reset values
    repeat (3) tick();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk_v("rst_v_out", v_out, '0);
    chk("rst_g_a", g_a, 64'd0);
    chk("rst_g_m1", g_m1, 64'd0);
    rst_n = 1;
    tick();

    // directed job: v[k]=k, m[k]=0x0101..01*k, C=0
    w1 = 64'h0101010101010101;
    for (int k = 0; k < 16; k++) begin
      va[64*k +: 64] = 64'(k);
      ma[64*k +: 64] = w1 * 64'(k);
    end
    ca = '0;
    ea = ref_model(va, ma, ca);
    start_job(va, ma, ca);
    chk("busy_in_ready", 64'(in_ready), 64'd0);
    for (int gi = 0; gi < 4; gi++) begin
      tick();
      chk($sformatf("col%0d_a", gi), g_a, 64'(gi));
      chk($sformatf("col%0d_b", gi), g_b, 64'(4 + gi));
      chk($sformatf("col%0d_c", gi), g_c, 64'(8 + gi));
      chk($sformatf("col%0d_d", gi), g_d, 64'(12 + gi));
      chk($sformatf("col%0d_m0", gi), g_m0, w1 * 64'(2 * gi));
      chk($sformatf("col%0d_m1", gi), g_m1, w1 * 64'(2 * gi + 1));
    end
    repeat (283) tick();
    chk("ov_at_287", 64'(out_valid), 64'd0);
    tick();
    chk("ov_at_288", 64'(out_valid), 64'd1);
    chk_v("job_a", v_out, ea);

    // back-pressure: hold 50 cycles, in_valid pulses ignored
    vx = rnd1024();
    v_in = vx; m_in = vx; c_in = vx;
    for (int i = 0; i < 50; i++) begin
      in_valid = i[0];
      tick();
      chk("hold_ov", 64'(out_valid), 64'd1);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      chk_v("hold_v_out", v_out, ea);
    end
    in_valid = 0;
    out_ready = 1;
    tick();
    out_ready = 0;
    chk("hs_ov", 64'(out_valid), 64'd0);
    chk("hs_in_ready", 64'(in_ready), 64'd1);

    // all-zero header stays zero through this G
    start_job('0, '0, '0);
    wait_done("zero");
    chk_v("zero_v_out", v_out, '0);
    out_ready = 1;
    tick();
    out_ready = 0;

    // random job with C, out_ready held high
    vb = rnd1024(); mb = rnd1024(); cb = rnd1024();
    eb = ref_model(vb, mb, cb);
    out_ready = 1;
    start_job(vb, mb, cb);
    tick();
    chk("rnd_m0", g_m0, mb[63:0] ^ cb[127:64]);
    chk("rnd_m1", g_m1, mb[127:64] ^ cb[63:0]);
    wait_done("rnd");
    chk_v("rnd_v_out", v_out, eb);
    tick();
    chk("pulse_ov", 64'(out_valid), 64'd0);
    chk("pulse_in_ready", 64'(in_ready), 64'd1);

    // reset 40 cycles into a job, then a fresh job
    start_job(rnd1024(), rnd1024(), rnd1024());
    repeat (40) tick();
    rst_n = 0;
    #1;
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_ov", 64'(out_valid), 64'd0);
    chk_v("mid_rst_v_out", v_out, '0);
    chk("mid_rst_g_a", g_a, 64'd0);
    chk("mid_rst_g_d", g_d, 64'd0);
    tick();
    rst_n = 1;
    vb = rnd1024(); mb = rnd1024(); cb = rnd1024();
    eb = ref_model(vb, mb, cb);
    start_job(vb, mb, cb);
    wait_done("post_rst");
    chk_v("post_rst_v_out", v_out, eb);
    tick();

    // in_valid during a job must not relatch
    vb = rnd1024(); mb = rnd1024(); cb = rnd1024();
    eb = ref_model(vb, mb, cb);
    start_job(vb, mb, cb);
    repeat (20) tick();
    v_in = rnd1024(); m_in = rnd1024(); c_in = rnd1024();
    in_valid = 1;
    repeat (3) begin
      tick();
      chk("relatch_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 0;
    wait_done("relatch");
    chk_v("relatch_v_out", v_out, eb);
    out_ready = 0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
